// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard controller: forwarding-source encoding,
// the tracked writer record and the small match/priority helpers.
package id_hazard_ctrl_pkg;

  localparam int SLOT_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_t;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [SLOT_AW-1:0] waddr;
    logic               is_load;
  } slot_t;

  localparam slot_t SLOT_IDLE = '{valid: 1'b0, we: 1'b0, waddr: {SLOT_AW{1'b0}}, is_load: 1'b0};

  // Load results only exist once the writer reaches WB, indexed by fwd_t.
  localparam logic [3:0] LOAD_FWD_OK = 4'b1000;

  function automatic logic slot_match(input slot_t s, input logic [SLOT_AW-1:0] raddr,
                                      input logic port_used);
    return s.valid & s.we & (s.waddr != {SLOT_AW{1'b0}}) & (s.waddr == raddr) & port_used;
  endfunction

  function automatic fwd_t pick_src(input logic hit_ex, input logic hit_mem, input logic hit_wb);
    fwd_t sel;
    if (hit_ex) begin
      sel = FWD_EX;
    end else if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  function automatic logic load_block(input fwd_t sel, input slot_t ex, input slot_t mem,
                                      input slot_t wb);
    logic src_is_load;
    case (sel)
      FWD_EX:  src_is_load = ex.is_load;
      FWD_MEM: src_is_load = mem.is_load;
      FWD_WB:  src_is_load = wb.is_load;
      default: src_is_load = 1'b0;
    endcase
    return src_is_load & ~LOAD_FWD_OK[sel];
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_slot.sv
// One tracked pipeline slot: loads from upstream, drops valid on outflow, else holds.
module hazard_slot
  import id_hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  clear,
  input  slot_t din,
  output slot_t q
);

  slot_t slot_r;

  // Slot register; an upstream load wins over a same-cycle outflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_r <= SLOT_IDLE;
    end else if (load) begin
      slot_r <= din;
    end else if (clear) begin
      slot_r.valid <= 1'b0;
    end else begin
      slot_r <= slot_r;
    end
  end

  assign q = slot_r;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage interlock and forwarding controller: tracks EX/MEM/WB writers, stalls on
// load-use and picks the youngest forwarding source for both read ports.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_valid,
  input  logic [REG_AW-1:0] ds_raddr1,
  input  logic [REG_AW-1:0] ds_raddr2,
  input  logic              ds_use1,
  input  logic              ds_use2,
  input  logic              ds_rf_we,
  input  logic [REG_AW-1:0] ds_rf_waddr,
  input  logic              ds_is_load,
  input  logic              ds_to_es_fire,
  input  logic              es_to_ms_fire,
  input  logic              ms_to_ws_fire,
  input  logic              ws_retire,
  input  logic              cnt_clr,
  output logic              stall,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t            ex_din_s;
  slot_t            ex_q_s;
  slot_t            mem_q_s;
  slot_t            wb_q_s;
  fwd_t             sel1_s;
  fwd_t             sel2_s;
  logic             stall_s;
  logic [CNT_W-1:0] stall_cnt_r;

  // Writes to r0 are tracked as non-writers so they never match a reader.
  always_comb begin
    ex_din_s         = SLOT_IDLE;
    ex_din_s.valid   = 1'b1;
    ex_din_s.we      = ds_rf_we & (ds_rf_waddr != {REG_AW{1'b0}});
    ex_din_s.waddr   = ds_rf_waddr;
    ex_din_s.is_load = ds_is_load;
  end

  hazard_slot u_ex_slot (
    .clk   (clk),
    .reset (reset),
    .load  (ds_to_es_fire),
    .clear (es_to_ms_fire),
    .din   (ex_din_s),
    .q     (ex_q_s)
  );

  hazard_slot u_mem_slot (
    .clk   (clk),
    .reset (reset),
    .load  (es_to_ms_fire),
    .clear (ms_to_ws_fire),
    .din   (ex_q_s),
    .q     (mem_q_s)
  );

  hazard_slot u_wb_slot (
    .clk   (clk),
    .reset (reset),
    .load  (ms_to_ws_fire),
    .clear (ws_retire),
    .din   (mem_q_s),
    .q     (wb_q_s)
  );

  // Youngest matching writer supplies each port; a load there that has not reached WB stalls ID.
  always_comb begin
    sel1_s = pick_src(slot_match(ex_q_s,  ds_raddr1, ds_use1),
                      slot_match(mem_q_s, ds_raddr1, ds_use1),
                      slot_match(wb_q_s,  ds_raddr1, ds_use1));
    sel2_s = pick_src(slot_match(ex_q_s,  ds_raddr2, ds_use2),
                      slot_match(mem_q_s, ds_raddr2, ds_use2),
                      slot_match(wb_q_s,  ds_raddr2, ds_use2));
    if (ds_valid) begin
      stall_s = load_block(sel1_s, ex_q_s, mem_q_s, wb_q_s) |
                load_block(sel2_s, ex_q_s, mem_q_s, wb_q_s);
    end else begin
      stall_s = 1'b0;
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall     = stall_s;
  assign fwd_sel1  = sel1_s;
  assign fwd_sel2  = sel2_s;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: expected outputs are queued as stimulus is
// driven and compared half a cycle later, away from the clock edge.
module tb_id_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ds_valid, ds_use1, ds_use2, ds_rf_we, ds_is_load;
  logic [4:0]    ds_raddr1, ds_raddr2, ds_rf_waddr;
  logic          ds_to_es_fire, es_to_ms_fire, ms_to_ws_fire, ws_retire, cnt_clr;
  logic          stall;
  logic [1:0]    fwd_sel1, fwd_sel2;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ds_valid      (ds_valid),
    .ds_raddr1     (ds_raddr1),
    .ds_raddr2     (ds_raddr2),
    .ds_use1       (ds_use1),
    .ds_use2       (ds_use2),
    .ds_rf_we      (ds_rf_we),
    .ds_rf_waddr   (ds_rf_waddr),
    .ds_is_load    (ds_is_load),
    .ds_to_es_fire (ds_to_es_fire),
    .es_to_ms_fire (es_to_ms_fire),
    .ms_to_ws_fire (ms_to_ws_fire),
    .ws_retire     (ws_retire),
    .cnt_clr       (cnt_clr),
    .stall         (stall),
    .fwd_sel1      (fwd_sel1),
    .fwd_sel2      (fwd_sel2),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    string         tag;
    logic          stall;
    logic [1:0]    f1;
    logic [1:0]    f2;
    bit            chk_cnt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // ID must never fire into EX while it is being told to stall.
  always @(posedge clk) begin
    if (!reset && stall && ds_to_es_fire) begin
      $error("FAIL protocol: ds_to_es_fire while stall");
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic st, input logic [1:0] a,
                          input logic [1:0] b, input bit cc, input logic [CW-1:0] c);
    exp_t e;
    e.tag = tag; e.stall = st; e.f1 = a; e.f2 = b; e.chk_cnt = cc; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
      check_val({e.tag, ".fwd1"}, 32'(fwd_sel1), 32'(e.f1));
      check_val({e.tag, ".fwd2"}, 32'(fwd_sel2), 32'(e.f2));
      if (e.chk_cnt) begin
        check_val({e.tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
      end
    end
  endtask

  task automatic clear_in();
    ds_valid = 1'b0; ds_use1 = 1'b0; ds_use2 = 1'b0; ds_rf_we = 1'b0; ds_is_load = 1'b0;
    ds_raddr1 = 5'd0; ds_raddr2 = 5'd0; ds_rf_waddr = 5'd0;
    ds_to_es_fire = 1'b0; es_to_ms_fire = 1'b0; ms_to_ws_fire = 1'b0; ws_retire = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    ds_valid = v; ds_raddr1 = r1; ds_use1 = u1; ds_raddr2 = r2; ds_use2 = u2;
  endtask

  task automatic fire(input logic we, input logic [4:0] wa, input logic ld);
    ds_to_es_fire = 1'b1; ds_rf_we = we; ds_rf_waddr = wa; ds_is_load = ld;
  endtask

  task automatic flows(input logic es, input logic ms, input logic ws);
    es_to_ms_fire = es; ms_to_ws_fire = ms; ws_retire = ws;
  endtask

  task automatic step();
    @(negedge clk);
    drain_sb();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      flows(1'b1, 1'b1, 1'b1);
      step();
    end
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push_exp("rst", 1'b0, 2'd0, 2'd0, 1'b1, 4'd0); step();

    // Non-load writer r5 walks EX -> MEM -> WB while ID reads it on port 1.
    fire(1'b1, 5'd5, 1'b0); push_exp("ex_fill", 1'b0, 2'd0, 2'd0, 1'b0, 4'd0); step();
    set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1); flows(1'b1, 1'b0, 1'b0);
    push_exp("fwd_ex", 1'b0, 2'd1, 2'd0, 1'b0, 4'd0); step();
    set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1); flows(1'b0, 1'b1, 1'b0);
    push_exp("fwd_mem", 1'b0, 2'd2, 2'd0, 1'b0, 4'd0); step();
    set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1); flows(1'b0, 1'b0, 1'b1);
    push_exp("fwd_wb", 1'b0, 2'd3, 2'd0, 1'b0, 4'd0); step();
    set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1);
    push_exp("fwd_gone", 1'b0, 2'd0, 2'd0, 1'b1, 4'd0); step();

    // ld.w r4 in EX, dependent add on port 2: two stall cycles then WB forward.
    fire(1'b1, 5'd4, 1'b1); step();
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1); flows(1'b1, 1'b0, 1'b0);
    push_exp("lu_ex", 1'b1, 2'd0, 2'd1, 1'b1, 4'd0); step();
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1); flows(1'b0, 1'b1, 1'b0);
    push_exp("lu_mem", 1'b1, 2'd0, 2'd2, 1'b1, 4'd1); step();
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1); fire(1'b1, 5'd6, 1'b0); flows(1'b0, 1'b0, 1'b1);
    push_exp("lu_wb", 1'b0, 2'd0, 2'd3, 1'b1, 4'd2); step();
    push_exp("lu_cnt", 1'b0, 2'd0, 2'd0, 1'b1, 4'd2); step();
    flush();

    // Younger non-load writer in EX shadows the older load in MEM.
    fire(1'b1, 5'd4, 1'b1); step();
    fire(1'b1, 5'd4, 1'b0); flows(1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b1);
    push_exp("shadow", 1'b0, 2'd1, 2'd1, 1'b1, 4'd2); step();
    flush();

    // ds_valid gates stall but not forwarding; then clear the counter.
    fire(1'b1, 5'd9, 1'b1); step();
    set_id(1'b0, 5'd9, 1'b1, 5'd9, 1'b1);
    push_exp("nvalid", 1'b0, 2'd1, 2'd1, 1'b1, 4'd2); step();
    set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1);
    push_exp("valid_stall", 1'b1, 2'd1, 2'd1, 1'b1, 4'd2); step();
    push_exp("cnt3", 1'b0, 2'd0, 2'd0, 1'b1, 4'd3); step();
    cnt_clr = 1'b1; step();
    push_exp("clr_done", 1'b0, 2'd0, 2'd0, 1'b1, 4'd0); step();
    flush();

    // r0 writer never matches; an unused port never matches.
    fire(1'b1, 5'd0, 1'b0); step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1); fire(1'b1, 5'd8, 1'b1);
    push_exp("r0", 1'b0, 2'd0, 2'd0, 1'b0, 4'd0); step();
    set_id(1'b1, 5'd8, 1'b0, 5'd8, 1'b0);
    push_exp("nouse", 1'b0, 2'd0, 2'd0, 1'b0, 4'd0); step();
    set_id(1'b1, 5'd8, 1'b0, 5'd8, 1'b1);
    push_exp("use2", 1'b1, 2'd0, 2'd1, 1'b1, 4'd0); step();
    flush();
    cnt_clr = 1'b1; step();

    // Held load-use stall drives the counter to saturation, then clear wins.
    fire(1'b1, 5'd4, 1'b1); step();
    for (int i = 0; i < 18; i++) begin
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
      step();
    end
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    push_exp("sat", 1'b1, 2'd1, 2'd0, 1'b1, 4'hF); step();
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0); cnt_clr = 1'b1;
    push_exp("sat_clr", 1'b1, 2'd1, 2'd0, 1'b1, 4'hF); step();
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    push_exp("after_clr", 1'b1, 2'd1, 2'd0, 1'b1, 4'd0); step();

    // Asynchronous reset in the middle of a stall.
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    push_exp("rst_async", 1'b0, 2'd0, 2'd0, 1'b1, 4'd0);
    drain_sb();
    @(posedge clk);
    #1 reset = 1'b0;
    clear_in();
    set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b1);
    push_exp("rst_idle", 1'b0, 2'd0, 2'd0, 1'b1, 4'd0); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
